// File: rtl/cnt_ramp_ctrl.sv
// Command-side driver for a load/up/down saturating counter: jump (single load) or ramp
// (one step per interval) to a target. Optional readback check under CNT_STALL_CHK_EN.
module cnt_ramp_ctrl #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [DIV_W-1:0] rate_div_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] cnt_val_i,
  input  logic             cnt_high_i,
  input  logic             cnt_low_i,
  output logic             load_o,
  output logic [WIDTH-1:0] load_val_o,
  output logic             up_o,
  output logic             down_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StStep,
    StSettle,
    StWait,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic             jump_q, jump_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             dir_up_q, dir_up_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef CNT_STALL_CHK_EN
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             stall_err;
`endif

  // Outputs are registered on entry to the state that owns them, so a strobe is high
  // during exactly the cycle its state is occupied.
  always_comb begin
    state_d    = state_q;
    jump_d     = jump_q;
    target_d   = target_q;
    div_d      = div_q;
    wait_cnt_d = wait_cnt_q;
    dir_up_d   = dir_up_q;
    load_d     = 1'b0;
    load_val_d = load_val_q;
    up_d       = 1'b0;
    down_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
`ifdef CNT_STALL_CHK_EN
    snap_d     = snap_q;
    stall_err  = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          jump_d   = jump_i;
          target_d = target_i;
          div_d    = rate_div_i;
          error_d  = 1'b0;
          busy_d   = 1'b1;
          if (jump_i) begin
            state_d    = StLoad;
            load_d     = 1'b1;
            load_val_d = target_i;
          end else begin
            state_d = StCheck;
          end
        end
      end

      StLoad: state_d = StSettle;

      StCheck: begin
`ifdef CNT_STALL_CHK_EN
        snap_d = cnt_val_i;
`endif
        if (cnt_val_i == target_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt_val_i < target_q) begin
          if (cnt_high_i) begin
            // Up needed but counter already saturated: inconsistent target/readback.
            state_d = StIdle;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = StStep;
            up_d     = 1'b1;
            dir_up_d = 1'b1;
          end
        end else begin
          if (cnt_low_i) begin
            state_d = StIdle;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d  = StStep;
            down_d   = 1'b1;
            dir_up_d = 1'b0;
          end
        end
      end

      StStep: state_d = StSettle;

      StSettle: begin
`ifdef CNT_STALL_CHK_EN
        if (jump_q) begin
          stall_err = (cnt_val_i != target_q);
        end else if (dir_up_q) begin
          stall_err = (cnt_val_i != (snap_q + WIDTH'(1)));
        end else begin
          stall_err = (cnt_val_i != (snap_q - WIDTH'(1)));
        end
        if (stall_err) begin
          state_d = StIdle;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else
`endif
        if (jump_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (div_q == '0) begin
          state_d = StCheck;
        end else begin
          state_d    = StWait;
          wait_cnt_d = div_q - DIV_W'(1);
        end
      end

      StWait: begin
        if (wait_cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          wait_cnt_d = wait_cnt_q - DIV_W'(1);
        end
      end

      StDone: state_d = StIdle;

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over everything outside IDLE; error is left as it was.
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
      load_d  = 1'b0;
      up_d    = 1'b0;
      down_d  = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      error_d = error_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      jump_q     <= 1'b0;
      target_q   <= '0;
      div_q      <= '0;
      wait_cnt_q <= '0;
      dir_up_q   <= 1'b0;
      load_q     <= 1'b0;
      load_val_q <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef CNT_STALL_CHK_EN
      snap_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      jump_q     <= jump_d;
      target_q   <= target_d;
      div_q      <= div_d;
      wait_cnt_q <= wait_cnt_d;
      dir_up_q   <= dir_up_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      up_q       <= up_d;
      down_q     <= down_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef CNT_STALL_CHK_EN
      snap_q     <= snap_d;
`endif
    end
  end

  assign load_o     = load_q;
  assign load_val_o = load_val_q;
  assign up_o       = up_q;
  assign down_o     = down_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: doc/cnt_ramp_ctrl.md
Name: cnt_ramp_ctrl

Overview:
- Command-side driver for the 5-bit load/up/down saturating counter interface. It generates load, up and down strobes and reads back the counter value and its high/low flags.
- On a request, it moves the counter to a target value in one of two ways: a single load (jump mode), or one unit step per programmable interval (ramp mode).
- It reports busy, done and error to the control logic that sits above the counter.

Parameters:
- WIDTH, 5, counter width; target, cnt_val and load_val share this width.
- DIV_W, 8, width of the rate_div step-interval input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  start request; sampled only in IDLE.
- jump  input  1  mode, sampled with req: 1 = load target directly, 0 = ramp.
- target  input  WIDTH  destination count, sampled with req.
- rate_div  input  DIV_W  extra wait cycles between ramp steps, sampled with req.
- abort  input  1  stop the current operation and return to IDLE.
- cnt_val  input  WIDTH  counter value read back.
- cnt_high  input  1  counter at all-ones.
- cnt_low  input  1  counter at zero.
- load  output  1  load strobe to counter.
- load_val  output  WIDTH  value presented with load.
- up  output  1  increment strobe.
- down  output  1  decrement strobe.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when cnt_val == target is reached.
- error  output  1  sticky error flag; cleared by the next accepted req.

Behaviour:
- Reset (async, rst_n=0): state IDLE; load=up=down=busy=done=error=0; load_val=0; internal divider=0.
- All outputs are registered. At most one of load/up/down is high in any cycle. Every strobe is exactly 1 cycle wide.
- IDLE:
  - busy=0. When req=1, capture jump, target and rate_div, clear error, set busy=1 on the next edge.
  - jump=1 -> LOAD; jump=0 -> CHECK.
- LOAD:
  - Drive load=1 and load_val=target for one cycle -> SETTLE.
- CHECK (ramp):
  - cnt_val==target -> DONE.
  - cnt_val<target -> drive up=1 for one cycle -> SETTLE.
  - cnt_val>target -> drive down=1 for one cycle -> SETTLE.
- SETTLE:
  - Exactly one cycle, so the counter's update after a strobe is visible on cnt_val before any decision.
  - Then: came from LOAD -> DONE; otherwise -> WAIT.
- WAIT:
  - Count rate_div cycles, then -> CHECK.
  - rate_div=0 means no wait, so the minimum ramp step period is 3 cycles (strobe, settle, check).
- DONE: pulse done=1 for one cycle, set busy=0, -> IDLE.
- Latency:
  - Jump mode: done asserts 3 cycles after the cycle in which req is sampled.
  - Ramp mode: |target-start|*(3+rate_div)+2 cycles.
- Boundary conditions:
  - req while busy: ignored, no queuing.
  - abort: any non-IDLE state -> IDLE next edge; strobes forced low; busy=0; no done pulse; error unchanged.
  - abort and req together in IDLE: req is accepted; abort is ignored in IDLE.
  - cnt_high=1 when an up step is needed, or cnt_low=1 when a down step is needed: set error=1, set busy=0, -> IDLE with no strobe and no done. This case means an inconsistent target or readback.
  - No arithmetic on cnt_val beyond compare; no wrap-around is ever requested.
  - target equal to the current value in ramp mode: done asserts 2 cycles after req (IDLE->CHECK->DONE); no strobe is issued.

Optional Feature:
- Macro: CNT_STALL_CHK_EN.
- Defined:
  - In SETTLE after an up/down strobe, compare cnt_val with the value captured in CHECK.
  - If it did not change by exactly +1 (up) or -1 (down): set error=1, abort the ramp to IDLE, busy=0, no done.
  - After LOAD, cnt_val must equal target, otherwise set error.
  - Adds one WIDTH-bit capture register.
- Not defined: no readback check; SETTLE always proceeds as described above.

Test Plan:
- Jump: counter at 3, req with jump=1, target=20 -> load pulse with load_val=20 for 1 cycle; done 3 cycles after req; counter=20; up/down never high.
- Ramp up: counter at 5, req with jump=0, target=9, rate_div=2 -> exactly 4 up pulses, 5 cycles apart; done once with counter=9; busy high throughout.
- Ramp down to floor: counter at 2, target=0, rate_div=0 -> 2 down pulses 3 cycles apart; done; cnt_low=1; error=0.
- Abort: ramp 0->31, abort after the 3rd up pulse -> no further strobes; busy=0 next cycle; no done; counter=3; a new req is accepted afterwards.
- Same value and busy-req: counter at 12, ramp target=12 -> done 2 cycles after req with no strobes; a second req during a busy ramp has no effect.
- CNT_STALL_CHK_EN: counter model holds its value on up (stuck), target=10 from 4 -> error=1 after the first SETTLE, no done; with the macro undefined, the same stimulus never sets error.
